pool_stream_ctrl: RTL

// Sequences one IMAGE_SIZE x IMAGE_SIZE frame of packed multi-channel pixels into the pooling layer.

---
 rtl/cnn_pkg.sv | 12 +
 rtl/pool_stream_ctrl_if.sv | 30 +++
 rtl/cnn_out_fifo.sv | 39 +++
 rtl/pool_stream_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared controller state type and pooling geometry helper.
package cnn_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} pool_ctrl_state_t;

    function automatic int pool_out_count(input int image, input int filter, input int stride);
        int side;
        side = (image - filter) / stride + 1;
        return side * side;
    endfunction

endpackage

// File: rtl/pool_stream_ctrl_if.sv
// pool_stream_ctrl_if: pixel-in, datapath and pooled-out signals of the pooling stream controller.
interface pool_stream_ctrl_if #(parameter int DATA_WIDTH = 80);

    logic                  start;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  dp_clk_en;
    logic [DATA_WIDTH-1:0] dp_input_data;
    logic [DATA_WIDTH-1:0] dp_output_data;
    logic                  dp_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  frame_done;
    logic                  count_error;

    // master is the controller; slave is the source, datapath and sink around it
    modport master (
        input  start, in_data, in_valid, dp_output_data, dp_valid, out_ready,
        output in_ready, dp_clk_en, dp_input_data, out_data, out_valid, busy, frame_done, count_error
    );

    modport slave (
        output start, in_data, in_valid, dp_output_data, dp_valid, out_ready,
        input  in_ready, dp_clk_en, dp_input_data, out_data, out_valid, busy, frame_done, count_error
    );

endinterface

// File: rtl/cnn_out_fifo.sv
// cnn_out_fifo: 2-entry FIFO holding pooled results; simultaneous push and pop keep the count.
module cnn_out_fifo #(
    parameter int DATA_WIDTH = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr, rd_ptr, do_push, do_pop;

    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end

endmodule

// File: rtl/pool_stream_ctrl.sv
// pool_stream_ctrl: drives one raster frame through the pooling datapath, flushes it, and
// buffers pooled results as a valid/ready stream under a 2-deep credit scheme.
module pool_stream_ctrl
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = 80,
    parameter int IMAGE_SIZE   = 15,
    parameter int FILTER_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    pool_stream_ctrl_if.master io
);

    localparam int OUT_PER_FRAME = pool_out_count(IMAGE_SIZE, FILTER_SIZE, STRIDE);
    localparam int PW  = $clog2(IMAGE_SIZE);
    localparam int CW  = $clog2(OUT_PER_FRAME + 1) + 1;
    localparam int DCW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    pool_ctrl_state_t state, state_nx;
    logic [PW-1:0]    row, col;
    logic [CW-1:0]    out_cnt;
    logic [DCW-1:0]   drain_cnt;
    logic [1:0]       fifo_count;
    logic             en_d, space, beat, last_col, last_beat, drain_en, drain_last;
    logic             busy, capture, push, pop, done, fifo_full, fifo_empty;
    logic             frame_done, count_error;

    // An issued enable reserves a FIFO slot until its result lands one cycle later
    assign space      = ({1'b0, fifo_count} + {2'b0, en_d}) < 3'd2;
    assign busy       = state != IDLE;
    assign beat       = io.in_valid && io.in_ready;
    assign drain_en   = state == DRAIN && space;
    assign last_col   = col == PW'(IMAGE_SIZE - 1);
    assign last_beat  = beat && last_col && row == PW'(IMAGE_SIZE - 1);
    assign drain_last = drain_en && drain_cnt == DCW'(DRAIN_CYCLES - 1);
    assign done       = state == FINISH && fifo_empty && !en_d;
    assign capture    = en_d && io.dp_valid && busy;
    assign push       = capture && !fifo_full && out_cnt < CW'(OUT_PER_FRAME);
    assign pop        = io.out_valid && io.out_ready;

    assign io.in_ready      = state == STREAM && space;
    assign io.dp_clk_en     = beat || drain_en;
    assign io.dp_input_data = state == STREAM ? io.in_data : '0;
    assign io.out_valid     = !fifo_empty;
    assign io.busy          = busy;
    assign io.frame_done    = frame_done;
    assign io.count_error   = count_error;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   state_nx = io.start ? STREAM : IDLE;
            STREAM: state_nx = last_beat ? DRAIN : STREAM;
            DRAIN:  state_nx = drain_last ? FINISH : DRAIN;
            FINISH: state_nx = done ? IDLE : FINISH;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            out_cnt     <= '0;
            drain_cnt   <= '0;
            en_d        <= 1'b0;
            frame_done  <= 1'b0;
            count_error <= 1'b0;
        end else begin
            state      <= state_nx;
            en_d       <= io.dp_clk_en;
            frame_done <= done;
            if (state == IDLE && io.start) begin
                row         <= '0;
                col         <= '0;
                out_cnt     <= '0;
                drain_cnt   <= '0;
                count_error <= 1'b0;
            end else begin
                if (beat) begin
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col) row <= last_beat ? '0 : row + 1'b1;
                end
                if (drain_en) drain_cnt <= drain_cnt + 1'b1;
                if (push) out_cnt <= out_cnt + 1'b1;
                if ((capture && !push) || (done && out_cnt != CW'(OUT_PER_FRAME))) count_error <= 1'b1;
            end
        end

    cnn_out_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (io.dp_output_data),
        .data    (io.out_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
